// File: rtl/n_bit_adder.sv
// Purpose: N-bit ripple-carry two's-complement adder, the accumulate datapath of the shift-add multipliers.
// Latency: answer is combinational (0 cycles); answer_q (and flags_q) follow 1 cycle later.
// Backpressure: none; the registers update on every rising clk edge with no enable or handshake.
// Optional carry/overflow flags are built when N_BIT_ADDER_FLAGS_EN is defined.
module n_bit_adder #(
  parameter int N = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic [N-1:0] answer,
`ifdef N_BIT_ADDER_FLAGS_EN
  output logic         carry_out,
  output logic         overflow,
  output logic [1:0]   flags_q,
`endif
  output logic [N-1:0] answer_q
);

  // Highest carry actually built: c[N] exists only when the flags consume it.
`ifdef N_BIT_ADDER_FLAGS_EN
  localparam int CTOP = N;
`else
  localparam int CTOP = N - 1;
`endif

  logic [CTOP:0] c;
  logic [N-1:0]  s;

  // Carry into bit 0 is always zero: this is a plain adder, not add-with-carry.
  assign c[0] = 1'b0;

  // Ripple chain: one full-adder cell per bit, carry feeding the next cell.
  for (genvar i = 0; i < N; i++) begin : g_fa
    logic p;
    assign p    = input1[i] ^ input2[i];
    assign s[i] = p ^ c[i];
    if (i < CTOP) begin : g_carry
      assign c[i+1] = (input1[i] & input2[i]) | (c[i] & p);
    end
  end

  // The multiplier samples this in the same cycle, so it bypasses the registers
  // and is never cleared by reset.
  assign answer = s;

  logic [N-1:0] answer_d;

  // Next value of the registered sum is simply the current combinational sum.
  always_comb begin
    answer_d = s;
  end

  // Registered sum for pipelined consumers; cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      answer_q <= '0;
    end else begin
      answer_q <= answer_d;
    end
  end

`ifdef N_BIT_ADDER_FLAGS_EN
  // Unsigned carry is the final carry; signed overflow is a carry mismatch
  // into and out of the sign bit.
  assign carry_out = c[N];
  assign overflow  = c[N] ^ c[N-1];

  logic [1:0] flags_d;

  // Flags are registered alongside the sum as {carry_out, overflow}.
  always_comb begin
    flags_d = {carry_out, overflow};
  end

  // Registered flags share the sum register's reset and timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 2'b00;
    end else begin
      flags_q <= flags_d;
    end
  end
`endif

endmodule

// File: tb/tb_n_bit_adder.sv
// Directed and random checks of n_bit_adder at N=17 and N=8.
module tb_n_bit_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] a17, b17, ans17, ansq17;
  logic [7:0]  a8, b8, ans8, ansq8;
`ifdef N_BIT_ADDER_FLAGS_EN
  logic        co17, ov17, co8, ov8;
  logic [1:0]  fq17, fq8;
`endif

  int checks = 0;
  int errors = 0;

  logic [16:0] mc;
  logic [8:0]  mp;
  logic [16:0] acc;
  logic [31:0] r1, r2;
  logic [17:0] s17;
  logic [8:0]  s8;

  always #5 clk = ~clk;

  n_bit_adder #(.N(17)) dut17 (
    .clk(clk), .rst(rst), .input1(a17), .input2(b17), .answer(ans17),
`ifdef N_BIT_ADDER_FLAGS_EN
    .carry_out(co17), .overflow(ov17), .flags_q(fq17),
`endif
    .answer_q(ansq17)
  );

  n_bit_adder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .input1(a8), .input2(b8), .answer(ans8),
`ifdef N_BIT_ADDER_FLAGS_EN
    .carry_out(co8), .overflow(ov8), .flags_q(fq8),
`endif
    .answer_q(ansq8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset: registered outputs clear, combinational sum keeps tracking.
    a17 = 17'h00005; b17 = 17'h0000A; a8 = 8'h03; b8 = 8'h04;
    #2;
    check("rst_ansq17", 32'(ansq17), 32'h0);
    check("rst_ansq8", 32'(ansq8), 32'h0);
    check("rst_ans17", 32'(ans17), 32'h0000F);
    check("rst_ans8", 32'(ans8), 32'h07);
`ifdef N_BIT_ADDER_FLAGS_EN
    check("rst_fq17", 32'(fq17), 32'h0);
`endif
    @(posedge clk); #1;
    check("rst_hold_ansq17", 32'(ansq17), 32'h0);
    @(negedge clk); rst = 1'b0;

    // 1 + 1, then the first edge after reset captures the sum.
    a17 = 17'h00001; b17 = 17'h00001;
    #1;
    check("t1_ans", 32'(ans17), 32'h00002);
    @(posedge clk); #1;
    check("t1_ansq", 32'(ansq17), 32'h00002);

    // All-ones + 1 wraps to zero with an unsigned carry.
    a17 = 17'h1FFFF; b17 = 17'h00001; a8 = 8'hFF; b8 = 8'h01;
    #1;
    check("t2_ans17", 32'(ans17), 32'h0);
    check("t2_ans8", 32'(ans8), 32'h0);
`ifdef N_BIT_ADDER_FLAGS_EN
    check("t2_co", 32'(co17), 32'h1);
    check("t2_ov", 32'(ov17), 32'h0);
    check("t2_co8", 32'(co8), 32'h1);
`endif
    @(posedge clk); #1;
    check("t2_ansq", 32'(ansq17), 32'h0);
`ifdef N_BIT_ADDER_FLAGS_EN
    check("t2_fq", 32'(fq17), 32'h2);
`endif

    // Max positive + 1 -> min negative, signed overflow only.
    a17 = 17'h0FFFF; b17 = 17'h00001; a8 = 8'h7F; b8 = 8'h01;
    #1;
    check("t3a_ans17", 32'(ans17), 32'h10000);
    check("t3a_ans8", 32'(ans8), 32'h80);
`ifdef N_BIT_ADDER_FLAGS_EN
    check("t3a_co", 32'(co17), 32'h0);
    check("t3a_ov", 32'(ov17), 32'h1);
    check("t3a_ov8", 32'(ov8), 32'h1);
`endif
    @(posedge clk); #1;
    check("t3a_ansq", 32'(ansq17), 32'h10000);
`ifdef N_BIT_ADDER_FLAGS_EN
    check("t3a_fq", 32'(fq17), 32'h1);
`endif

    // Min negative + min negative -> zero with carry and overflow.
    a17 = 17'h10000; b17 = 17'h10000; a8 = 8'h80; b8 = 8'h80;
    #1;
    check("t3b_ans17", 32'(ans17), 32'h0);
    check("t3b_ans8", 32'(ans8), 32'h0);
`ifdef N_BIT_ADDER_FLAGS_EN
    check("t3b_co", 32'(co17), 32'h1);
    check("t3b_ov", 32'(ov17), 32'h1);
`endif
    @(posedge clk); #1;
`ifdef N_BIT_ADDER_FLAGS_EN
    check("t3b_fq", 32'(fq17), 32'h3);
    check("t3b_fq8", 32'(fq8), 32'h3);
`endif

    // Reset asserted between edges while the inputs are held.
    a17 = 17'h00123; b17 = 17'h00456;
    @(posedge clk); #1;
    check("t4_pre_ansq", 32'(ansq17), 32'h00579);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_ansq", 32'(ansq17), 32'h0);
    check("t4_rst_ans", 32'(ans17), 32'h00579);
`ifdef N_BIT_ADDER_FLAGS_EN
    check("t4_rst_fq", 32'(fq17), 32'h0);
`endif
    #1 rst = 1'b0;
    #1;
    check("t4_rel_noedge", 32'(ansq17), 32'h0);
    @(posedge clk); #1;
    check("t4_rel_ansq", 32'(ansq17), 32'h00579);

    // Shift-add multiply of -3 (8'hFD) by 5 (9'h005) using the combinational sum.
    // The multiplier's sign bit is 0 here, so no final subtract step is needed.
    mc  = {{9{1'b1}}, 8'hFD};
    mp  = 9'h005;
    acc = 17'h0;
    for (int i = 0; i < 9; i++) begin
      if (mp[i]) begin
        a17 = acc;
        b17 = mc << i;
        #1;
        acc = ans17;
      end
    end
    check("t6_mul", 32'(acc), 32'h1FFF1);
    @(posedge clk); #1;

    // Random operands on both widths; registered sum checked one edge later.
    for (int i = 0; i < 2000; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      a17 = r1[16:0]; b17 = r2[16:0];
      a8  = r1[31:24]; b8 = r2[31:24];
      s17 = {1'b0, r1[16:0]} + {1'b0, r2[16:0]};
      s8  = {1'b0, r1[31:24]} + {1'b0, r2[31:24]};
      #1;
      check("rnd_ans17", 32'(ans17), 32'(s17[16:0]));
      check("rnd_ans8", 32'(ans8), 32'(s8[7:0]));
`ifdef N_BIT_ADDER_FLAGS_EN
      check("rnd_co17", 32'(co17), 32'(s17[17]));
      check("rnd_ov17", 32'(ov17),
            32'((r1[16] == r2[16]) && (s17[16] != r1[16])));
`endif
      @(posedge clk); #1;
      check("rnd_ansq17", 32'(ansq17), 32'(s17[16:0]));
      check("rnd_ansq8", 32'(ansq8), 32'(s8[7:0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
